reg_wport_arbiter: RTL and testbench

REG_WPORT_ARBITER -- requirements
Module: reg_wport_arbiter

---
 rtl/reg_wport_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_wport_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback versus a 2-deep FIFO of
// multi-cycle results, with starvation forcing and pending-write queries.
module reg_wport_arbiter #(
  parameter int DATA_W       = 32,
  parameter int RS_W         = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [RS_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              mc_valid,
  input  logic [RS_W-1:0]   mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_regwrite,
  output logic [RS_W-1:0]   rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [RS_W-1:0]   q_rs1,
  input  logic [RS_W-1:0]   q_rs2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [1:0]        mc_count
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [RS_W-1:0]   rd_mem   [2];
  logic [DATA_W-1:0] data_mem [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic [SC_W-1:0]   starve_reg;
  logic [SC_W-1:0]   starve_next;

  logic force_mc;
  logic wb_grant;
  logic mc_grant;
  logic push;
  logic [1:0] entry_valid;
  logic [1:0] hit1_e;
  logic [1:0] hit2_e;

  assign mc_count = count_reg;
  assign force_mc = (starve_reg == SC_W'(STARVE_LIMIT)) && (count_reg != 2'd0);
  assign wb_ready = !rst && !force_mc;
  assign mc_ready = (count_reg < 2'd2) && !rst;
  assign wb_grant = wb_valid && wb_ready;
  // WB has priority unless the MC head has been starved out
  assign mc_grant = !rst && (count_reg != 2'd0) && (force_mc || !wb_valid);
  assign push     = mc_valid && mc_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !mc_grant)
      count_next = count_reg + 2'd1;
    else if (!push && mc_grant)
      count_next = count_reg - 2'd1;
  end

  always_comb begin
    starve_next = starve_reg;
    if (mc_grant || count_reg == 2'd0)
      starve_next = '0;
    else if (starve_reg != SC_W'(STARVE_LIMIT))
      starve_next = starve_reg + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      starve_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= !wr_ptr_reg;
      if (mc_grant)
        rd_ptr_reg <= !rd_ptr_reg;
      count_reg  <= count_next;
      starve_reg <= starve_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= mc_rd;
      data_mem[wr_ptr_reg] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_regwrite   <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
    end else if (mc_grant) begin
      rf_regwrite   <= (rd_mem[rd_ptr_reg] != '0);
      rf_rd         <= rd_mem[rd_ptr_reg];
      rf_write_data <= data_mem[rd_ptr_reg];
    end else if (wb_grant) begin
      rf_regwrite   <= (wb_rd != '0);
      rf_rd         <= wb_rd;
      rf_write_data <= wb_data;
    end else begin
      rf_regwrite <= 1'b0;
    end
  end

  // An entry is live if the FIFO is full, or it is the sole entry at the head
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign entry_valid[gi] = (count_reg == 2'd2) ||
                             ((count_reg == 2'd1) && (rd_ptr_reg == 1'(gi)));
    assign hit1_e[gi] = entry_valid[gi] && (rd_mem[gi] == q_rs1);
    assign hit2_e[gi] = entry_valid[gi] && (rd_mem[gi] == q_rs2);
  end

  assign q_hit1 = (q_rs1 != '0) && ((|hit1_e) || (rf_regwrite && rf_rd == q_rs1));
  assign q_hit2 = (q_rs2 != '0) && ((|hit2_e) || (rf_regwrite && rf_rd == q_rs2));

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Directed bench for reg_wport_arbiter: writeback, conflict, starvation,
// FIFO-full, x0 handling, queries and mid-operation reset.
module tb_reg_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_regwrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_hit1;
  logic        q_hit2;
  logic [1:0]  mc_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = !clk;

  reg_wport_arbiter #(.DATA_W(32), .RS_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .mc_count(mc_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0; q_rs1 = '0; q_rs2 = '0;

    // Reset state
    tick(); tick();
    check("rst_wb_ready", wb_ready, 0);
    check("rst_mc_ready", mc_ready, 0);
    check("rst_regwrite", rf_regwrite, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_count", mc_count, 0);
    rst = 1'b0; #1;
    check("rel_wb_ready", wb_ready, 1);
    check("rel_mc_ready", mc_ready, 1);
    $display("txn reset: done");

    // WB only
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; #1;
    check("wb_only_ready", wb_ready, 1);
    tick(); wb_valid = 1'b0;
    check("wb_only_we", rf_regwrite, 1);
    check("wb_only_rd", rf_rd, 5);
    check("wb_only_data", rf_write_data, 32'hDEAD);
    tick();
    check("idle_we", rf_regwrite, 0);
    check("idle_rd_hold", rf_rd, 5);
    $display("txn wb_only: rd=5 data=dead");

    // Conflict: WB rd3 wins, MC rd7 queued then written
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h77; #1;
    check("cf_wb_ready", wb_ready, 1);
    check("cf_mc_ready", mc_ready, 1);
    tick(); wb_valid = 1'b0; mc_valid = 1'b0;
    q_rs1 = 5'd7; q_rs2 = 5'd3; #1;
    check("cf_rd_wb", rf_rd, 3);
    check("cf_we_wb", rf_regwrite, 1);
    check("cf_count1", mc_count, 1);
    check("cf_hit1_fifo", q_hit1, 1);
    check("cf_hit2_rf", q_hit2, 1);
    tick();
    check("cf_rd_mc", rf_rd, 7);
    check("cf_data_mc", rf_write_data, 32'h77);
    check("cf_count0", mc_count, 0);
    $display("txn conflict: wb rd=3 then mc rd=7");

    // Starvation
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h40;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0;
    tick(); mc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sv_wb_ready_%0d", i), wb_ready, 1);
      tick();
    end
    check("sv_rd_wb", rf_rd, 4);
    check("sv_forced", wb_ready, 0);
    check("sv_count1", mc_count, 1);
    tick();
    check("sv_rd_mc", rf_rd, 10);
    check("sv_data_mc", rf_write_data, 32'hA0);
    check("sv_count0", mc_count, 0);
    check("sv_ready_back", wb_ready, 1);
    tick();
    check("sv_rd_wb2", rf_rd, 4);
    $display("txn starve: mc rd=10 forced after 4 lost cycles");

    // FIFO full
    wb_rd = 5'd1; wb_data = 32'h1;
    mc_valid = 1'b1; mc_rd = 5'd11; mc_data = 32'hB1;
    tick();
    check("ff_count1", mc_count, 1);
    mc_rd = 5'd12; mc_data = 32'hB2; #1;
    check("ff_ready1", mc_ready, 1);
    tick();
    check("ff_count2", mc_count, 2);
    mc_rd = 5'd13; mc_data = 32'hB3; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ff_not_ready_%0d", i), mc_ready, 0);
      tick();
    end
    check("ff_forced", wb_ready, 0);
    check("ff_no_bypass", mc_ready, 0);
    tick();
    check("ff_rd11", rf_rd, 11);
    check("ff_count_pop", mc_count, 1);
    check("ff_ready_again", mc_ready, 1);
    tick(); wb_valid = 1'b0; mc_valid = 1'b0;
    check("ff_rd_wb", rf_rd, 1);
    check("ff_count_refill", mc_count, 2);
    tick();
    check("ff_rd12", rf_rd, 12);
    tick();
    check("ff_rd13", rf_rd, 13);
    check("ff_data13", rf_write_data, 32'hB3);
    check("ff_empty", mc_count, 0);
    $display("txn fifo_full: order 11,1,12,13");

    // x0 through the MC path
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
    tick(); mc_valid = 1'b0;
    check("x0_count1", mc_count, 1);
    tick();
    check("x0_we", rf_regwrite, 0);
    check("x0_popped", mc_count, 0);
    $display("txn x0: popped without write");

    // Queries with rd9 held in the FIFO
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
    tick();
    mc_rd = 5'd14; mc_data = 32'hE0; wb_rd = 5'd6; wb_data = 32'h66;
    q_rs1 = 5'd9; q_rs2 = 5'd2; #1;
    check("q_hit1_fifo9", q_hit1, 1);
    check("q_hit2_rf2", q_hit2, 1);
    q_rs1 = 5'd0; q_rs2 = 5'd8; #1;
    check("q_hit1_x0", q_hit1, 0);
    check("q_hit2_miss", q_hit2, 0);
    tick();
    q_rs1 = 5'd14; #1;
    check("q_count2", mc_count, 2);
    check("q_we6", rf_regwrite, 1);
    check("q_hit1_second", q_hit1, 1);
    $display("txn query: hits on 9,2,14");

    // Reset mid-operation
    rst = 1'b1; #1;
    check("mr_wb_ready", wb_ready, 0);
    check("mr_mc_ready", mc_ready, 0);
    tick();
    check("mr_count", mc_count, 0);
    check("mr_we", rf_regwrite, 0);
    check("mr_rd", rf_rd, 0);
    check("mr_data", rf_write_data, 0);
    check("mr_hit_stale", q_hit1, 0);
    rst = 1'b0; wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    check("mr_no_write1", rf_regwrite, 0);
    check("mr_ready", mc_ready, 1);
    tick();
    check("mr_no_write2", rf_regwrite, 0);
    check("mr_count_after", mc_count, 0);
    $display("txn mid_reset: fifo discarded");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
